// File: rtl/rom_layer_sequencer_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer.
package rom_layer_sequencer_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned RELU_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUT
  } seq_state_t;

  // Operates on a sign-extended copy so one helper serves any ACC_WIDTH up to 64.
  function automatic logic signed [RELU_W-1:0] relu_clamp(
    input logic signed [RELU_W-1:0] v,
    input logic                     en
  );
    return (en && v[RELU_W-1]) ? '0 : v;
  endfunction

endpackage

// File: rtl/rom_layer_sequencer_if.sv
// Control, weight-ROM, activation-buffer and result-stream signals of the layer sequencer.
interface rom_layer_sequencer_if
  import rom_layer_sequencer_pkg::*;
#(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32
);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [ADDR_W-1:0]    w_addr;
  logic [W_WIDTH-1:0]   w_data;
  logic [ADDR_W-1:0]    x_addr;
  logic [A_WIDTH-1:0]   x_data;
  logic                 y_valid;
  logic                 y_ready;
  logic [ACC_WIDTH-1:0] y_data;
  logic [ADDR_W-1:0]    y_idx;

  modport master (
    input  start, w_data, x_data, y_ready,
    output busy, done, w_addr, x_addr, y_valid, y_data, y_idx
  );

  modport slave (
    output start, w_data, x_data, y_ready,
    input  busy, done, w_addr, x_addr, y_valid, y_data, y_idx
  );

endinterface

// File: rtl/rom_layer_sequencer_mac.sv
// Signed multiply-accumulate: signed weight times zero-extended unsigned activation.
module mac_unit #(
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        en,
  input  logic [W_WIDTH-1:0]          w,
  input  logic [A_WIDTH-1:0]          x,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam int unsigned P_WIDTH = W_WIDTH + A_WIDTH + 1;

  logic signed [P_WIDTH-1:0]   w_ext;
  logic signed [P_WIDTH-1:0]   x_ext;
  logic signed [P_WIDTH-1:0]   prod;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  // acc includes the pair currently on w/x, so the final sum is visible in the drain cycle.
  always_comb begin
    w_ext = {{(A_WIDTH + 1){w[W_WIDTH-1]}}, w};
    x_ext = {{(W_WIDTH + 1){1'b0}}, x};
    prod  = w_ext * x_ext;
    acc_d = acc_q + {{(ACC_WIDTH - P_WIDTH){prod[P_WIDTH-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_d;

endmodule

// File: rtl/rom_layer_sequencer.sv
// Sequences one fully-connected layer over a 1-cycle-latency weight ROM and activation buffer.
module rom_layer_sequencer
  import rom_layer_sequencer_pkg::*;
#(
  parameter int unsigned N_IN      = 784,
  parameter int unsigned N_OUT     = 16,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 32,
  parameter bit          RELU      = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  rom_layer_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(N_OUT - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  seq_state_t                  state_q, state_d;
  logic [ADDR_W-1:0]           w_addr_q, w_addr_d;
  logic [ADDR_W-1:0]           x_addr_q, x_addr_d;
  logic [ADDR_W-1:0]           neuron_q, neuron_d;
  logic [ADDR_W-1:0]           y_idx_q, y_idx_d;
  logic [ACC_WIDTH-1:0]        y_data_q, y_data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        y_valid_q, y_valid_d;
  logic                        rd_v_q;
  logic                        mac_clr;
  logic signed [ACC_WIDTH-1:0] mac_acc;

  mac_unit #(
    .W_WIDTH  (W_WIDTH),
    .A_WIDTH  (A_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (rd_v_q),
    .w    (bus.w_data),
    .x    (bus.x_data),
    .acc  (mac_acc)
  );

  always_comb begin
    state_d   = state_q;
    w_addr_d  = w_addr_q;
    x_addr_d  = x_addr_q;
    neuron_d  = neuron_q;
    y_idx_d   = y_idx_q;
    y_data_d  = y_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    y_valid_d = y_valid_q;
    mac_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // done_q blocks a start that coincides with the done pulse
        if (bus.start && !done_q) begin
          state_d  = FETCH;
          neuron_d = '0;
          w_addr_d = '0;
          x_addr_d = '0;
          busy_d   = 1'b1;
          mac_clr  = 1'b1;
        end
      end
      FETCH: begin
        if (x_addr_q == LAST_I) begin
          state_d = DRAIN;
        end else begin
          w_addr_d = w_addr_q + ONE;
          x_addr_d = x_addr_q + ONE;
        end
      end
      DRAIN: begin
        y_data_d  = ACC_WIDTH'(relu_clamp(RELU_W'(mac_acc), RELU));
        y_idx_d   = neuron_q;
        y_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (bus.y_ready) begin
          y_valid_d = 1'b0;
          mac_clr   = 1'b1;
          if (neuron_q == LAST_N) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // weight rows are contiguous, so the next row starts one past the last address
            neuron_d = neuron_q + ONE;
            w_addr_d = w_addr_q + ONE;
            x_addr_d = '0;
            state_d  = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      w_addr_q  <= '0;
      x_addr_q  <= '0;
      neuron_q  <= '0;
      y_idx_q   <= '0;
      y_data_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      y_valid_q <= 1'b0;
      rd_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_addr_q  <= w_addr_d;
      x_addr_q  <= x_addr_d;
      neuron_q  <= neuron_d;
      y_idx_q   <= y_idx_d;
      y_data_q  <= y_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      y_valid_q <= y_valid_d;
      rd_v_q    <= (state_q == FETCH);
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.w_addr  = w_addr_q;
  assign bus.x_addr  = x_addr_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_idx   = y_idx_q;

endmodule

// File: tb/tb_rom_layer_sequencer.sv
// Directed bench: two small layers (ReLU on/off) and one 784-input layer with ROM models.
module tb_rom_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic cmode;
  int   checks = 0;
  int   errors = 0;
  int   sweep_bad;

  always #5 clk = ~clk;

  rom_layer_sequencer_if #(.W_WIDTH(8), .A_WIDTH(8), .ACC_WIDTH(32)) busA ();
  rom_layer_sequencer_if #(.W_WIDTH(8), .A_WIDTH(8), .ACC_WIDTH(32)) busB ();
  rom_layer_sequencer_if #(.W_WIDTH(8), .A_WIDTH(8), .ACC_WIDTH(32)) busC ();

  rom_layer_sequencer #(.N_IN(4), .N_OUT(2), .W_WIDTH(8), .A_WIDTH(8), .ACC_WIDTH(32), .RELU(1'b1))
    dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  rom_layer_sequencer #(.N_IN(4), .N_OUT(2), .W_WIDTH(8), .A_WIDTH(8), .ACC_WIDTH(32), .RELU(1'b0))
    dutB (.clk(clk), .rst_n(rst_n), .bus(busB));
  rom_layer_sequencer #(.N_IN(784), .N_OUT(2), .W_WIDTH(8), .A_WIDTH(8), .ACC_WIDTH(32), .RELU(1'b0))
    dutC (.clk(clk), .rst_n(rst_n), .bus(busC));

  // Small layer weights {1,2,3,4 | -1,-1,-1,-1}, activations all 1.
  logic [7:0] wrom4 [8];
  initial begin
    wrom4[0] = 8'h01; wrom4[1] = 8'h02; wrom4[2] = 8'h03; wrom4[3] = 8'h04;
    wrom4[4] = 8'hFF; wrom4[5] = 8'hFF; wrom4[6] = 8'hFF; wrom4[7] = 8'hFF;
  end

  // Synchronous 1-cycle ROM / activation buffer models.
  always @(posedge clk) begin
    busA.w_data <= wrom4[busA.w_addr[2:0]];
    busA.x_data <= 8'd1;
    busB.w_data <= wrom4[busB.w_addr[2:0]];
    busB.x_data <= 8'd1;
    if (cmode == 1'b0) begin
      busC.w_data <= (busC.w_addr < 16'd784) ? 8'h01 : 8'hFF;
      busC.x_data <= 8'd2;
    end else begin
      busC.w_data <= 8'h80;
      busC.x_data <= 8'd255;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_valid_c(input string tag, input int limit);
    int n = 0;
    while (busC.y_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busC.y_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmode = 1'b0;
    busA.start = 1'b0; busB.start = 1'b0; busC.start = 1'b0;
    busA.y_ready = 1'b1; busB.y_ready = 1'b1; busC.y_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_busy",   {31'd0, busA.busy}, 0);
    check("rst_done",   {31'd0, busC.done}, 0);
    check("rst_yvalid", {31'd0, busB.y_valid}, 0);
    check("rst_waddr",  {16'd0, busC.w_addr}, 0);
    check("rst_xaddr",  {16'd0, busC.x_addr}, 0);
    check("rst_ydata",  busA.y_data, 0);
    check("rst_yidx",   {16'd0, busA.y_idx}, 0);

    rst_n = 1'b1;
    @(negedge clk);
    check("early_ready_no_valid", {31'd0, busA.y_valid}, 0);

    // Small layers A (ReLU) and B (signed) in lockstep.
    busA.start = 1'b1; busB.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0; busB.start = 1'b0;
    check("t1_busy", {31'd0, busA.busy}, 1);
    check("t1_first_waddr", {16'd0, busA.w_addr}, 0);
    repeat (4) @(negedge clk);
    check("t1_valid_early", {31'd0, busA.y_valid}, 0);
    @(negedge clk);
    check("t1_latency_valid", {31'd0, busA.y_valid}, 1);
    check("t1_y0", busA.y_data, 32'd10);
    check("t1_idx0", {16'd0, busA.y_idx}, 0);
    check("t2_y0", busB.y_data, 32'd10);
    @(negedge clk);
    check("t1_valid_drop", {31'd0, busA.y_valid}, 0);
    check("t1_next_waddr", {16'd0, busA.w_addr}, 4);
    check("t1_next_xaddr", {16'd0, busA.x_addr}, 0);
    repeat (5) @(negedge clk);
    check("t1_valid1", {31'd0, busA.y_valid}, 1);
    check("t1_y1_relu", busA.y_data, 32'd0);
    check("t1_idx1", {16'd0, busA.y_idx}, 1);
    check("t2_y1_signed", busB.y_data, 32'hFFFFFFFC);
    check("t1_done_early", {31'd0, busA.done}, 0);
    @(negedge clk);
    check("t1_done", {31'd0, busA.done}, 1);
    check("t1_busy_off", {31'd0, busA.busy}, 0);
    check("t2_done", {31'd0, busB.done}, 1);
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    check("t1_done_once", {31'd0, busA.done}, 0);
    check("t1_start_on_done_ignored", {31'd0, busA.busy}, 0);

    // 784-input layer: address sweep, with a start pulse while busy.
    busC.start = 1'b1;
    @(negedge clk);
    busC.start = 1'b0;
    check("t3_busy", {31'd0, busC.busy}, 1);
    sweep_bad = 0;
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 784; k++) begin
        if (busC.w_addr !== 16'(n * 784 + k) || busC.x_addr !== 16'(k)) sweep_bad++;
        busC.start = (n == 0 && k == 100);
        @(negedge clk);
      end
      check("t3_drain_hold", {16'd0, busC.w_addr}, 32'(n * 784 + 783));
      check("t3_drain_novalid", {31'd0, busC.y_valid}, 0);
      @(negedge clk);
      check("t3_yvalid", {31'd0, busC.y_valid}, 1);
      check("t3_ydata", busC.y_data, (n == 0) ? 32'd1568 : 32'hFFFFF9E0);
      check("t3_yidx", {16'd0, busC.y_idx}, 32'(n));
      @(negedge clk);
    end
    check("t3_sweep", 32'(sweep_bad), 0);
    check("t3_done", {31'd0, busC.done}, 1);
    check("t3_busy_off", {31'd0, busC.busy}, 0);

    // Extremes with back-pressure: w=-128, x=255 -> -25589760.
    @(negedge clk);
    cmode = 1'b1;
    busC.y_ready = 1'b0;
    busC.start = 1'b1;
    @(negedge clk);
    busC.start = 1'b0;
    wait_valid_c("t5_valid", 2000);
    for (int c = 0; c < 10; c++) begin
      check("t4_hold_valid", {31'd0, busC.y_valid}, 1);
      check("t4_hold_ydata", busC.y_data, 32'hFE798800);
      check("t4_hold_yidx", {16'd0, busC.y_idx}, 0);
      check("t4_hold_waddr", {16'd0, busC.w_addr}, 783);
      @(negedge clk);
    end
    busC.y_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", {31'd0, busC.y_valid}, 0);
    check("t4_release_waddr", {16'd0, busC.w_addr}, 784);

    // Reset in the middle of neuron 1's fetch.
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busC.busy}, 0);
    check("t6_rst_waddr", {16'd0, busC.w_addr}, 0);
    check("t6_rst_xaddr", {16'd0, busC.x_addr}, 0);
    check("t6_rst_ydata", busC.y_data, 0);
    check("t6_rst_yvalid", {31'd0, busC.y_valid}, 0);
    repeat (3) @(negedge clk);
    check("t6_no_done", {31'd0, busC.done}, 0);
    rst_n = 1'b1;
    cmode = 1'b0;
    @(negedge clk);
    busC.start = 1'b1;
    @(negedge clk);
    busC.start = 1'b0;
    wait_valid_c("t6_valid0", 2000);
    check("t6_y0", busC.y_data, 32'd1568);
    check("t6_idx0", {16'd0, busC.y_idx}, 0);
    @(negedge clk);
    wait_valid_c("t6_valid1", 2000);
    check("t6_y1", busC.y_data, 32'hFFFFF9E0);
    check("t6_idx1", {16'd0, busC.y_idx}, 1);
    @(negedge clk);
    check("t6_done", {31'd0, busC.done}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
